// File: rtl/matmul_host_sequencer.sv
// rtl/matmul_host_sequencer.sv - loads 8 operand bytes into a 2x2 multiplier and streams out the 4 results
// Optional: MATMUL_SEQ_CHECKSUM_EN appends a fifth XOR-checksum word to each result set.
module matmul_host_sequencer #(
  parameter int DATA_W   = 8,
  parameter int RESULT_W = 2*DATA_W+1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [RESULT_W-1:0] out_data,
  output logic                out_last,
  output logic                busy,
  output logic [2:0]          mm_sel_in,
  output logic [DATA_W-1:0]   mm_input_val,
  output logic                mm_execute,
  output logic [1:0]          mm_sel_out,
  input  logic [RESULT_W-1:0] mm_result
);

`ifdef MATMUL_SEQ_CHECKSUM_EN
  typedef enum logic [2:0] {S_LOAD, S_SETTLE, S_CAPTURE, S_PRESENT, S_CHECK} state_t;
  logic [RESULT_W-1:0] r_csum;
`else
  typedef enum logic [1:0] {S_LOAD, S_SETTLE, S_CAPTURE, S_PRESENT} state_t;
`endif

  state_t              r_state;
  logic [2:0]          r_idx;
  logic [1:0]          r_k;
  logic                r_in_ready;
  logic                r_out_valid;
  logic [RESULT_W-1:0] r_out_data;
  logic                r_out_last;
  logic                r_busy;
  logic [2:0]          r_mm_sel_in;
  logic [DATA_W-1:0]   r_mm_input_val;
  logic                r_mm_execute;
  logic [1:0]          r_mm_sel_out;
  logic                w_in_fire;
  logic                w_out_fire;

  assign w_in_fire  = in_valid && r_in_ready;
  assign w_out_fire = r_out_valid && out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= S_LOAD;
      r_idx          <= 3'd0;
      r_k            <= 2'd0;
      r_in_ready     <= 1'b1;
      r_out_valid    <= 1'b0;
      r_out_data     <= '0;
      r_out_last     <= 1'b0;
      r_busy         <= 1'b0;
      r_mm_sel_in    <= 3'd0;
      r_mm_input_val <= '0;
      r_mm_execute   <= 1'b0;
      r_mm_sel_out   <= 2'd0;
`ifdef MATMUL_SEQ_CHECKSUM_EN
      r_csum         <= '0;
`endif
    end else begin
      case (r_state)
        S_LOAD: begin
          // Operand regs only move on an accepted byte, so the multiplier's
          // continuous writes while execute=0 just repeat the same value.
          if (w_in_fire) begin
            r_mm_sel_in    <= r_idx;
            r_mm_input_val <= in_data;
            r_idx          <= r_idx + 3'd1;
            r_busy         <= 1'b1;
            if (r_idx == 3'd7) begin
              r_in_ready <= 1'b0;
              r_state    <= S_SETTLE;
`ifdef MATMUL_SEQ_CHECKSUM_EN
              r_csum     <= '0;
`endif
            end
          end
        end
        S_SETTLE: begin
          r_mm_execute <= 1'b1;
          r_mm_sel_out <= 2'd0;
          r_k          <= 2'd0;
          r_state      <= S_CAPTURE;
        end
        S_CAPTURE: begin
          r_out_data  <= mm_result;
          r_out_valid <= 1'b1;
`ifdef MATMUL_SEQ_CHECKSUM_EN
          r_out_last  <= 1'b0;
          r_csum      <= r_csum ^ mm_result;
`else
          r_out_last  <= (r_k == 2'd3);
`endif
          r_state     <= S_PRESENT;
        end
        S_PRESENT: begin
          if (w_out_fire) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            if (r_k != 2'd3) begin
              r_k          <= r_k + 2'd1;
              r_mm_sel_out <= r_k + 2'd1;
              r_state      <= S_CAPTURE;
            end else begin
              r_mm_execute <= 1'b0;
              r_idx        <= 3'd0;
`ifdef MATMUL_SEQ_CHECKSUM_EN
              r_out_valid  <= 1'b1;
              r_out_data   <= r_csum;
              r_out_last   <= 1'b1;
              r_state      <= S_CHECK;
`else
              r_in_ready   <= 1'b1;
              r_busy       <= 1'b0;
              r_state      <= S_LOAD;
`endif
            end
          end
        end
`ifdef MATMUL_SEQ_CHECKSUM_EN
        S_CHECK: begin
          if (w_out_fire) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_LOAD;
          end
        end
`endif
        default: r_state <= S_LOAD;
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign out_last     = r_out_last;
  assign busy         = r_busy;
  assign mm_sel_in    = r_mm_sel_in;
  assign mm_input_val = r_mm_input_val;
  assign mm_execute   = r_mm_execute;
  assign mm_sel_out   = r_mm_sel_out;

endmodule

// File: tb/tb_matmul_host_sequencer.sv
// tb/tb_matmul_host_sequencer.sv - scoreboard bench for matmul_host_sequencer with a behavioural 2x2 multiplier
// Honours MATMUL_SEQ_CHECKSUM_EN for the expected word stream.
module tb_matmul_host_sequencer;
  localparam int DW = 8;
  localparam int RW = 17;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic [2:0]    mm_sel_in;
  logic [DW-1:0] mm_input_val;
  logic          mm_execute;
  logic [1:0]    mm_sel_out;
  logic [RW-1:0] mm_result;

  always #5 clk = ~clk;

  matmul_host_sequencer #(.DATA_W(DW), .RESULT_W(RW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy),
    .mm_sel_in(mm_sel_in), .mm_input_val(mm_input_val), .mm_execute(mm_execute),
    .mm_sel_out(mm_sel_out), .mm_result(mm_result)
  );

  // Multiplier core: writes operand[sel_in] each cycle while not executing.
  logic [DW-1:0] op [8];
  always @(posedge clk) if (!mm_execute) op[mm_sel_in] <= mm_input_val;
  always_comb begin
    mm_result = '0;
    case (mm_sel_out)
      2'd0: mm_result = RW'(op[0]) * RW'(op[4]) + RW'(op[1]) * RW'(op[6]);
      2'd1: mm_result = RW'(op[0]) * RW'(op[5]) + RW'(op[1]) * RW'(op[7]);
      2'd2: mm_result = RW'(op[2]) * RW'(op[4]) + RW'(op[3]) * RW'(op[6]);
      default: mm_result = RW'(op[2]) * RW'(op[5]) + RW'(op[3]) * RW'(op[7]);
    endcase
  end

  typedef struct packed { logic [RW-1:0] data; logic last; } exp_t;
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   stall_en = 1'b0;
  int   stall_cnt = 0;
`ifdef MATMUL_SEQ_CHECKSUM_EN
  localparam int WORDS_PER_SET = 5;
`else
  localparam int WORDS_PER_SET = 4;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_set(input int c00, input int c01, input int c10, input int c11);
    exp_t e;
    e.data = RW'(c00); e.last = 1'b0; sb.push_back(e);
    e.data = RW'(c01); sb.push_back(e);
    e.data = RW'(c10); sb.push_back(e);
`ifdef MATMUL_SEQ_CHECKSUM_EN
    e.data = RW'(c11); sb.push_back(e);
    e.data = RW'(c00 ^ c01 ^ c10 ^ c11); e.last = 1'b1; sb.push_back(e);
`else
    e.data = RW'(c11); e.last = 1'b1; sb.push_back(e);
`endif
  endtask

  // Leaves in_valid high; the caller decides when to drop it.
  task automatic send_byte(input logic [7:0] b);
    int t;
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 500) begin
        n_tests++; n_fail++;
        $display("FAIL send_byte_timeout: in_ready never rose for byte %0d", b);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic send_set(input logic [63:0] v);
    for (int i = 0; i < 8; i++) send_byte(v[63-8*i -: 8]);
  endtask

  task automatic wait_drain(output int viol);
    int t;
    viol = 0;
    t = 0;
    while (sb.size() > 0 && t < 3000) begin
      @(posedge clk); #1;
      t++;
      if (sb.size() > 0 && in_ready) viol++;
    end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d words outstanding, required 0", sb.size());
    end
  endtask

  // Back-pressure driver: with stall_en, hold each word for 10 cycles before accepting.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (!stall_en) out_ready = 1'b1;
      else if (out_valid && !out_ready) begin
        if (stall_cnt == 9) out_ready = 1'b1;
        stall_cnt++;
      end else begin
        out_ready = 1'b0;
        stall_cnt = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on each handshake, checks stability under stall.
  logic          prev_stall = 1'b0;
  logic [RW-1:0] prev_data  = '0;
  always @(negedge clk) begin
    if (reset) begin
      if (prev_stall) begin
        check("stall_valid_held", {31'd0, out_valid}, 32'd1);
        check("stall_data_stable", {15'd0, out_data}, {15'd0, prev_data});
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_word: got %0d with empty scoreboard", out_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("word_data", {15'd0, out_data}, {15'd0, e.data});
          check("word_last", {31'd0, out_last}, {31'd0, e.last});
        end
      end
      prev_stall <= out_valid && !out_ready;
      prev_data  <= out_data;
    end else begin
      prev_stall <= 1'b0;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},   {31'd0, in_ready},   32'd1);
    check({tag, "_out_valid"},  {31'd0, out_valid},  32'd0);
    check({tag, "_out_data"},   {15'd0, out_data},   32'd0);
    check({tag, "_out_last"},   {31'd0, out_last},   32'd0);
    check({tag, "_busy"},       {31'd0, busy},       32'd0);
    check({tag, "_mm_sel_in"},  {29'd0, mm_sel_in},  32'd0);
    check({tag, "_mm_val"},     {24'd0, mm_input_val}, 32'd0);
    check({tag, "_mm_execute"}, {31'd0, mm_execute}, 32'd0);
    check({tag, "_mm_sel_out"}, {30'd0, mm_sel_out}, 32'd0);
  endtask

  initial begin
    int n;
    int viol;
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Test 1: basic set, latency and handshake flags.
    push_set(19, 22, 43, 50);
    send_byte(8'd1);
    check("busy_after_first_byte", {31'd0, busy}, 32'd1);
    send_byte(8'd2); send_byte(8'd3); send_byte(8'd4);
    send_byte(8'd5); send_byte(8'd6); send_byte(8'd7); send_byte(8'd8);
    in_valid = 1'b0;
    check("in_ready_low_in_settle", {31'd0, in_ready}, 32'd0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("first_valid_cycles_after_last_byte", n + 1, 32'd3);
    wait_drain(viol);
    check("busy_after_drain", {31'd0, busy}, 32'd0);
    check("in_ready_after_drain", {31'd0, in_ready}, 32'd1);

    // Test 2: worst-case operands.
    push_set(130050, 130050, 130050, 130050);
    send_set(64'hFFFF_FFFF_FFFF_FFFF);
    in_valid = 1'b0;
    wait_drain(viol);

    // Test 3: 10-cycle stall on every word.
    stall_en = 1'b1;
    push_set(19, 22, 43, 50);
    send_set(64'h0102_0304_0506_0708);
    in_valid = 1'b0;
    wait_drain(viol);
    check("in_ready_low_while_draining", viol, 32'd0);
    stall_en = 1'b0;
    @(posedge clk); #1;

    // Test 4: reset after 5 bytes, then a fresh set.
    send_byte(8'd9); send_byte(8'd9); send_byte(8'd9); send_byte(8'd9); send_byte(8'd9);
    in_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    push_set(8, 10, 22, 26);
    send_set(64'h0200_0103_0405_0607);
    in_valid = 1'b0;
    wait_drain(viol);

    // Test 5: in_valid held across two back-to-back sets.
    push_set(19, 22, 43, 50);
    push_set(9, 8, 7, 6);
    send_set(64'h0102_0304_0506_0708);
    send_byte(8'd1);
    check("second_set_waits_for_drain", sb.size(), WORDS_PER_SET);
    send_byte(8'd0); send_byte(8'd0); send_byte(8'd1);
    send_byte(8'd9); send_byte(8'd8); send_byte(8'd7); send_byte(8'd6);
    in_valid = 1'b0;
    wait_drain(viol);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
